// File: rtl/atm_pkg.sv
// Shared encodings between the ATM controller and the account server:
// request opcodes, response status codes and the server FSM states.
package atm_pkg;

    typedef enum logic [1:0] {
        OP_BAL = 2'b00,
        OP_DEP = 2'b01,
        OP_WDR = 2'b10,
        OP_END = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK         = 2'b00,
        ST_NOT_ENOUGH = 2'b01,
        ST_BAD_PIN    = 2'b10,
        ST_LOCKED     = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CHECK = 2'b01,
        S_EXEC  = 2'b10,
        S_RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/atm_pin_guard.sv
// Per-account consecutive wrong-PIN counters and sticky lock flags.
// A lock, once set, only clears on reset.
module atm_pin_guard #(
    parameter int N_ACCT    = 4,
    parameter int ACCT_W    = (N_ACCT > 1) ? $clog2(N_ACCT) : 1,
    parameter int MAX_TRIES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              check_i,
    input  logic [ACCT_W-1:0] acct_i,
    input  logic              match_i,
    output logic [N_ACCT-1:0] locked_o,
    output logic              lock_now_o
);

    localparam int CNT_W = $clog2(MAX_TRIES + 1);

    logic [CNT_W-1:0]  cnt_q [N_ACCT];
    logic [N_ACCT-1:0] locked_q;

    assign locked_o   = locked_q;
    assign lock_now_o = check_i && !match_i && !locked_q[acct_i]
                        && (cnt_q[acct_i] == CNT_W'(MAX_TRIES - 1));

    // Locked accounts are frozen: their counter already sits at MAX_TRIES.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_ACCT; i++) begin
                cnt_q[i] <= '0;
            end
            locked_q <= '0;
        end else if (check_i && !locked_q[acct_i]) begin
            if (match_i) begin
                cnt_q[acct_i] <= '0;
            end else if (cnt_q[acct_i] < CNT_W'(MAX_TRIES)) begin
                cnt_q[acct_i] <= cnt_q[acct_i] + 1'b1;
                if (lock_now_o) begin
                    locked_q[acct_i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/atm_account_server.sv
// Bank-side responder: validates PIN, applies balance/deposit/withdraw on the
// addressed account and returns status plus resulting balance.
module atm_account_server
    import atm_pkg::*;
#(
    parameter int                  N_ACCT    = 4,
    parameter int                  ACCT_W    = (N_ACCT > 1) ? $clog2(N_ACCT) : 1,
    parameter int                  BAL_W     = 8,
    parameter int                  AMT_W     = 4,
    parameter int                  MAX_TRIES = 3,
    parameter int                  INIT_BAL  = 20,
    parameter logic [4*N_ACCT-1:0] PIN_TABLE = {4'hC, 4'hA, 4'h5, 4'hF}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ACCT_W-1:0] req_acct,
    input  logic [3:0]        req_pin,
    input  logic [1:0]        req_op,
    input  logic [AMT_W-1:0]  req_amount,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [BAL_W-1:0]  rsp_balance,
    output logic [N_ACCT-1:0] acct_locked
);

    state_e             state_q;
    logic               ready_q;
    logic               rspValid_q;
    logic [1:0]         status_q;
    logic [BAL_W-1:0]   rspBal_q;
    logic [ACCT_W-1:0]  acct_q;
    logic [3:0]         pin_q;
    logic [1:0]         op_q;
    logic [AMT_W-1:0]   amt_q;
    logic [BAL_W-1:0]   bal_q [N_ACCT];

    logic               acctInRange_d;
    logic               pinMatch_d;
    logic               acctLocked_d;
    logic               guardCheck_d;
    logic               lockNow_d;
    logic [N_ACCT-1:0]  lockFlags;
    logic [BAL_W-1:0]   curBal_d;
    logic [BAL_W-1:0]   amtWide_d;
    logic [BAL_W:0]     depSum_d;
    logic [BAL_W-1:0]   depBal_d;

    assign req_ready   = ready_q;
    assign rsp_valid   = rspValid_q;
    assign rsp_status  = status_q;
    assign rsp_balance = rspBal_q;
    assign acct_locked = lockFlags;

    // Deposits saturate at all-ones rather than wrapping.
    always_comb begin
        acctInRange_d = ({1'b0, acct_q} < (ACCT_W + 1)'(N_ACCT));
        curBal_d      = acctInRange_d ? bal_q[acct_q] : '0;
        pinMatch_d    = acctInRange_d && (PIN_TABLE[acct_q*4 +: 4] == pin_q);
        acctLocked_d  = acctInRange_d && lockFlags[acct_q];
        guardCheck_d  = (state_q == S_CHECK) && acctInRange_d;
        amtWide_d     = BAL_W'(amt_q);
        depSum_d      = {1'b0, curBal_d} + {1'b0, amtWide_d};
        depBal_d      = depSum_d[BAL_W] ? '1 : depSum_d[BAL_W-1:0];
    end

    atm_pin_guard #(
        .N_ACCT    (N_ACCT),
        .ACCT_W    (ACCT_W),
        .MAX_TRIES (MAX_TRIES)
    ) u_pin_guard (
        .clk        (clk),
        .rst        (rst),
        .check_i    (guardCheck_d),
        .acct_i     (acct_q),
        .match_i    (pinMatch_d),
        .locked_o   (lockFlags),
        .lock_now_o (lockNow_d)
    );

    // req_ready is registered so it stays low through reset and rises one edge later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            rspValid_q <= 1'b0;
            status_q   <= ST_OK;
            rspBal_q   <= '0;
            acct_q     <= '0;
            pin_q      <= '0;
            op_q       <= '0;
            amt_q      <= '0;
            for (int i = 0; i < N_ACCT; i++) begin
                bal_q[i] <= BAL_W'(INIT_BAL);
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (req_valid && ready_q) begin
                        acct_q  <= req_acct;
                        pin_q   <= req_pin;
                        op_q    <= req_op;
                        amt_q   <= req_amount;
                        ready_q <= 1'b0;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!acctInRange_d) begin
                        status_q <= ST_BAD_PIN;
                        rspBal_q <= '0;
                        state_q  <= S_RESP;
                    end else if (acctLocked_d) begin
                        status_q <= ST_LOCKED;
                        rspBal_q <= '0;
                        state_q  <= S_RESP;
                    end else if (!pinMatch_d || lockNow_d) begin
                        status_q <= ST_BAD_PIN;
                        rspBal_q <= '0;
                        state_q  <= S_RESP;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    status_q <= ST_OK;
                    rspBal_q <= curBal_d;
                    state_q  <= S_RESP;
                    case (op_e'(op_q))
                        OP_DEP: begin
                            bal_q[acct_q] <= depBal_d;
                            rspBal_q      <= depBal_d;
                        end
                        OP_WDR: begin
                            if (amtWide_d > curBal_d) begin
                                status_q <= ST_NOT_ENOUGH;
                            end else begin
                                bal_q[acct_q] <= curBal_d - amtWide_d;
                                rspBal_q      <= curBal_d - amtWide_d;
                            end
                        end
                        default: ;
                    endcase
                end
                S_RESP: begin
                    if (!rspValid_q) begin
                        rspValid_q <= 1'b1;
                    end else if (rsp_ready) begin
                        rspValid_q <= 1'b0;
                        ready_q    <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_account_server.sv
// Self-checking bench for atm_account_server: directed scenarios plus random
// transactions compared against an account-level reference model.
module tb_atm_account_server;

    localparam int MAX_TRIES = 3;
    localparam int INIT_BAL  = 20;
    localparam int BAL_MAX   = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_acct = '0;
    logic [3:0] req_pin = '0;
    logic [1:0] req_op = '0;
    logic [3:0] req_amount = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [1:0] rsp_status;
    logic [7:0] rsp_balance;
    logic [3:0] acct_locked;

    int checks   = 0;
    int failures = 0;

    int         mBal   [4];
    int         mFails [4];
    logic [3:0] mLocked;
    int         pinTab [4] = '{15, 5, 10, 12};

    always #5 clk = ~clk;

    atm_account_server dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_acct    (req_acct),
        .req_pin     (req_pin),
        .req_op      (req_op),
        .req_amount  (req_amount),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_status  (rsp_status),
        .rsp_balance (rsp_balance),
        .acct_locked (acct_locked)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            mBal[i]   = INIT_BAL;
            mFails[i] = 0;
        end
        mLocked = '0;
    endtask

    // Account-level rules: lock check, PIN check, then the arithmetic on plain ints.
    task automatic predict(input int a, input int p, input int op, input int amt,
                           output int st, output int bal, output int lat);
        if (mLocked[a]) begin
            st = 3; bal = 0; lat = 2;
        end else if (p != pinTab[a]) begin
            if (mFails[a] < MAX_TRIES) mFails[a]++;
            if (mFails[a] >= MAX_TRIES) mLocked[a] = 1'b1;
            st = 2; bal = 0; lat = 2;
        end else begin
            mFails[a] = 0;
            st = 0; lat = 3;
            if (op == 1) begin
                mBal[a] = (mBal[a] + amt > BAL_MAX) ? BAL_MAX : mBal[a] + amt;
            end else if (op == 2) begin
                if (amt > mBal[a]) st = 1;
                else mBal[a] = mBal[a] - amt;
            end
            bal = mBal[a];
        end
    endtask

    task automatic waitReady(input string tag, output bit ok);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (req_ready === 1'b1);
        if (!ok) checkOutput({tag, "_ready_timeout"}, 0, 1);
    endtask

    task automatic applyStimulus(input int a, input int p, input int op, input int amt,
                                 input int holdCycles, input string tag);
        int st, eb, lat, n;
        bit ok, seen;
        predict(a, p, op, amt, st, eb, lat);
        rsp_ready = (holdCycles > 0) ? 1'b0 : 1'b1;
        waitReady(tag, ok);
        if (!ok) return;
        req_valid  = 1'b1;
        req_acct   = a[1:0];
        req_pin    = p[3:0];
        req_op     = op[1:0];
        req_amount = amt[3:0];
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        seen = 1'b0;
        for (n = 1; n <= 10; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checkOutput({tag, "_rsp_timeout"}, 0, 1);
            rsp_ready = 1'b1;
            return;
        end
        checkOutput({tag, "_latency"}, n, lat);
        checkOutput({tag, "_status"}, int'(rsp_status), st);
        checkOutput({tag, "_balance"}, int'(rsp_balance), eb);
        checkOutput({tag, "_locked"}, int'(acct_locked), int'(mLocked));
        checkOutput({tag, "_ready_busy"}, int'(req_ready), 0);
        for (int h = 0; h < holdCycles; h++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, "_hold_valid"}, int'(rsp_valid), 1);
            checkOutput({tag, "_hold_status"}, int'(rsp_status), st);
            checkOutput({tag, "_hold_balance"}, int'(rsp_balance), eb);
            checkOutput({tag, "_hold_ready"}, int'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_rsp_drop"}, int'(rsp_valid), 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req_ready"}, int'(req_ready), 0);
        checkOutput({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        checkOutput({tag, "_rsp_status"}, int'(rsp_status), 0);
        checkOutput({tag, "_rsp_balance"}, int'(rsp_balance), 0);
        checkOutput({tag, "_acct_locked"}, int'(acct_locked), 0);
    endtask

    initial begin
        bit ok;
        int a, p, op, amt;
        $display("[TB] start");
        modelReset();
        #1;
        checkAllZero("reset");
        repeat (3) @(negedge clk);
        checkAllZero("reset_hold");
        rst = 1'b1;

        applyStimulus(0, 15, 2, 4, 0, "wdr4");
        applyStimulus(0, 15, 1, 4, 0, "dep4");
        applyStimulus(0, 15, 2, 15, 0, "wdr15_a");
        applyStimulus(0, 15, 2, 15, 0, "wdr15_b");

        for (int i = 0; i < 3; i++) applyStimulus(1, 6, 0, 0, 0, "a1_bad");
        applyStimulus(1, 5, 2, 1, 0, "a1_locked");

        applyStimulus(2, 3, 0, 0, 0, "a2_bad_run1");
        applyStimulus(2, 3, 0, 0, 0, "a2_bad_run1");
        applyStimulus(2, 10, 0, 0, 0, "a2_good");
        for (int i = 0; i < 3; i++) applyStimulus(2, 3, 0, 0, 0, "a2_bad_run2");
        applyStimulus(2, 10, 0, 0, 0, "a2_locked");

        for (int i = 0; i < 16; i++) applyStimulus(3, 12, 1, 15, 0, "a3_dep");
        applyStimulus(3, 12, 1, 15, 5, "a3_dep_hold");
        applyStimulus(3, 12, 2, 0, 0, "a3_wdr0");
        applyStimulus(3, 12, 3, 7, 0, "a3_end");

        // Reset while the withdraw sits in EXEC; the balance must not move.
        rsp_ready = 1'b1;
        waitReady("midexec", ok);
        if (ok) begin
            req_valid  = 1'b1;
            req_acct   = 2'd0;
            req_pin    = 4'hF;
            req_op     = 2'd2;
            req_amount = 4'd4;
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            #1;
            checkAllZero("midexec_reset");
            modelReset();
            repeat (2) @(negedge clk);
            rst = 1'b1;
        end
        applyStimulus(0, 15, 0, 0, 0, "post_reset_bal");
        applyStimulus(1, 5, 0, 0, 0, "post_reset_unlock");

        for (int i = 0; i < 60; i++) begin
            a   = int'($urandom_range(0, 3));
            p   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : pinTab[a];
            op  = int'($urandom_range(0, 3));
            amt = int'($urandom_range(0, 15));
            applyStimulus(a, p, op, amt, int'($urandom_range(0, 2)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
